// File: rtl/grid_gen_pkg.sv
// grid_gen_pkg: shared state encoding, default parameter values and the
// seed-stepping helper for the grid generation sequencer.
package grid_gen_pkg;

  localparam int unsigned GG_LFSR_WIDTH     = 4;
  localparam int unsigned GG_MAX_TRIES      = 8;
  localparam int unsigned GG_SEED_STRIDE    = 5;
  localparam int unsigned GG_CLEAR_CYCLES   = 2;
  localparam int unsigned GG_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_REPORT = 2'd3
  } gen_state_t;

  // Advance a seed by the stride, never landing on zero (an all-zero LFSR
  // seed would lock the grid's generator).
  function automatic logic [31:0] f_seed_step(input logic [31:0] seed,
                                              input logic [31:0] stride,
                                              input int unsigned width);
    logic [31:0] mask;
    logic [31:0] s;
    if (width >= 32) mask = '1;
    else             mask = (32'd1 << width) - 32'd1;
    s = (seed + stride) & mask;
    if (s == 32'd0) s = stride & mask;
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/grid_gen_watchdog.sv
// grid_gen_watchdog: per-attempt cycle counter with a saturating expiry flag.
// Counts while run is high, restarts on clear.
module grid_gen_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: restart on clear, otherwise count up to LIMIT and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                                  cnt_d = '0;
    else if (run && (cnt_q != CNT_W'(LIMIT)))   cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = run && (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/grid_gen_sequencer.sv
// grid_gen_sequencer: runs whole puzzle-generation jobs on a grid instance:
// clear the grid, launch it with a seed, retry with a new seed on failure,
// then report outcome/tries/seed with a one-cycle done pulse.
// Optional per-attempt watchdog: define GRID_GEN_TIMEOUT_EN.
module grid_gen_sequencer
  import grid_gen_pkg::*;
#(
  parameter int unsigned LFSR_WIDTH     = GG_LFSR_WIDTH,
  parameter int unsigned MAX_TRIES      = GG_MAX_TRIES,
  parameter int unsigned SEED_STRIDE    = GG_SEED_STRIDE,
  parameter int unsigned CLEAR_CYCLES   = GG_CLEAR_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = GG_TIMEOUT_CYCLES,
  localparam int unsigned TRY_W         = $clog2(MAX_TRIES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rq_gen,
  input  logic                  rq_abort,
  input  logic [LFSR_WIDTH-1:0] base_seed,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic [TRY_W-1:0]      tries,
  output logic [LFSR_WIDTH-1:0] seed_used,
  output logic                  grid_reset,
  output logic                  grid_rq_start,
  output logic [LFSR_WIDTH-1:0] grid_seed,
  input  logic                  grid_done,
  input  logic                  grid_success
);

  localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);

  gen_state_t            state_q, state_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  success_q, success_d;
  logic [TRY_W-1:0]      tries_q, tries_d;
  logic [LFSR_WIDTH-1:0] seed_used_q, seed_used_d;
  logic                  grid_reset_q, grid_reset_d;
  logic                  grid_rq_start_q, grid_rq_start_d;
  logic [LFSR_WIDTH-1:0] grid_seed_q, grid_seed_d;
  logic                  timeout_hit;

`ifdef GRID_GEN_TIMEOUT_EN
  // Watchdog restarts whenever we are not launching, so every attempt gets
  // a fresh budget.
  grid_gen_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q != ST_LAUNCH),
    .run     (state_q == ST_LAUNCH),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; every output is a flop so the grid
  // and host see glitch-free, edge-aligned controls.
  always_comb begin
    state_d         = state_q;
    clr_cnt_d       = clr_cnt_q;
    done_d          = 1'b0;
    success_d       = success_q;
    tries_d         = tries_q;
    seed_used_d     = seed_used_q;
    grid_reset_d    = grid_reset_q;
    grid_rq_start_d = grid_rq_start_q;
    grid_seed_d     = grid_seed_q;
    case (state_q)
      ST_IDLE: begin
        grid_reset_d    = 1'b0;
        grid_rq_start_d = 1'b0;
        if (rq_gen) begin
          state_d      = ST_CLEAR;
          clr_cnt_d    = '0;
          grid_reset_d = 1'b1;
          grid_seed_d  = (base_seed == '0) ? LFSR_WIDTH'(1) : base_seed;
          tries_d      = TRY_W'(1);
          success_d    = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (rq_abort) begin
          state_d      = ST_REPORT;
          done_d       = 1'b1;
          success_d    = 1'b0;
          seed_used_d  = grid_seed_q;
          grid_reset_d = 1'b0;
        end else if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
          state_d         = ST_LAUNCH;
          grid_reset_d    = 1'b0;
          grid_rq_start_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_LAUNCH: begin
        // Abort wins over a grid completion in the same cycle.
        if (rq_abort || (grid_done && grid_success) ||
            ((grid_done || timeout_hit) && (tries_q == TRY_W'(MAX_TRIES)))) begin
          state_d         = ST_REPORT;
          done_d          = 1'b1;
          success_d       = !rq_abort && grid_done && grid_success;
          seed_used_d     = grid_seed_q;
          grid_rq_start_d = 1'b0;
        end else if (grid_done || timeout_hit) begin
          state_d         = ST_CLEAR;
          clr_cnt_d       = '0;
          grid_reset_d    = 1'b1;
          grid_rq_start_d = 1'b0;
          tries_d         = tries_q + 1'b1;
          grid_seed_d     = LFSR_WIDTH'(f_seed_step(32'(grid_seed_q),
                                                    32'(SEED_STRIDE), LFSR_WIDTH));
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; the grid is held in reset while we are.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      clr_cnt_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      success_q       <= 1'b0;
      tries_q         <= '0;
      seed_used_q     <= '0;
      grid_reset_q    <= 1'b1;
      grid_rq_start_q <= 1'b0;
      grid_seed_q     <= LFSR_WIDTH'(1);
    end else begin
      state_q         <= state_d;
      clr_cnt_q       <= clr_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      success_q       <= success_d;
      tries_q         <= tries_d;
      seed_used_q     <= seed_used_d;
      grid_reset_q    <= grid_reset_d;
      grid_rq_start_q <= grid_rq_start_d;
      grid_seed_q     <= grid_seed_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign success       = success_q;
  assign tries         = tries_q;
  assign seed_used     = seed_used_q;
  assign grid_reset    = grid_reset_q;
  assign grid_rq_start = grid_rq_start_q;
  assign grid_seed     = grid_seed_q;

endmodule

// File: tb/tb_grid_gen_sequencer.sv
// Directed bench for grid_gen_sequencer; the bench plays the grid by hand.
module tb_grid_gen_sequencer;

  logic       clock;
  logic       reset;
  logic       rq_gen;
  logic       rq_abort;
  logic [3:0] base_seed;
  logic       busy;
  logic       done;
  logic       success;
  logic [3:0] tries;
  logic [3:0] seed_used;
  logic       grid_reset;
  logic       grid_rq_start;
  logic [3:0] grid_seed;
  logic       grid_done;
  logic       grid_success;

  int errors = 0;
  int checks = 0;

  grid_gen_sequencer #(
    .LFSR_WIDTH(4), .MAX_TRIES(8), .SEED_STRIDE(5),
    .CLEAR_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock(clock), .reset(reset), .rq_gen(rq_gen), .rq_abort(rq_abort),
    .base_seed(base_seed), .busy(busy), .done(done), .success(success),
    .tries(tries), .seed_used(seed_used), .grid_reset(grid_reset),
    .grid_rq_start(grid_rq_start), .grid_seed(grid_seed),
    .grid_done(grid_done), .grid_success(grid_success)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!grid_rq_start && n < 50) begin
      tick();
      n++;
    end
    check("launch_seen", 32'(grid_rq_start), 32'd1);
  endtask

  task automatic finish_attempt(input logic ok);
    grid_done = 1'b1;
    grid_success = ok;
    tick();
    grid_done = 1'b0;
    grid_success = 1'b0;
  endtask

  task automatic accept(input logic [3:0] s);
    base_seed = s;
    rq_gen = 1'b1;
    tick();
    rq_gen = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; rq_gen = 1'b0; rq_abort = 1'b0; base_seed = 4'h0;
    grid_done = 1'b0; grid_success = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_success", 32'(success), 32'd0);
    check("rst_start", 32'(grid_rq_start), 32'd0);
    check("rst_tries", 32'(tries), 32'd0);
    check("rst_seed_used", 32'(seed_used), 32'd0);
    check("rst_grid_seed", 32'(grid_seed), 32'd1);
    check("rst_grid_reset", 32'(grid_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst_grid_reset", 32'(grid_reset), 32'd0);

    // First-try success with seed 3.
    accept(4'h3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_gr_c1", 32'(grid_reset), 32'd1);
    check("t1_seed", 32'(grid_seed), 32'h3);
    check("t1_start_c1", 32'(grid_rq_start), 32'd0);
    tick();
    check("t1_gr_c2", 32'(grid_reset), 32'd1);
    check("t1_start_c2", 32'(grid_rq_start), 32'd0);
    tick();
    check("t1_gr_c3", 32'(grid_reset), 32'd0);
    check("t1_start_c3", 32'(grid_rq_start), 32'd1);
    tick(); tick();
    check("t1_start_held", 32'(grid_rq_start), 32'd1);
    check("t1_no_early_done", 32'(done), 32'd0);
    finish_attempt(1'b1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_success", 32'(success), 32'd1);
    check("t1_tries", 32'(tries), 32'd1);
    check("t1_seed_used", 32'(seed_used), 32'h3);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_hold_success", 32'(success), 32'd1);

    // Two failures then success; seed wraps through zero to 5.
    accept(4'hB);
    wait_launch();
    check("t2_seed0", 32'(grid_seed), 32'hB);
    finish_attempt(1'b0);
    check("t2_retry_clear", 32'(grid_reset), 32'd1);
    check("t2_retry_nodone", 32'(done), 32'd0);
    check("t2_seed1", 32'(grid_seed), 32'h5);
    check("t2_tries1", 32'(tries), 32'd2);
    wait_launch();
    finish_attempt(1'b0);
    check("t2_seed2", 32'(grid_seed), 32'hA);
    wait_launch();
    finish_attempt(1'b1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_success", 32'(success), 32'd1);
    check("t2_tries", 32'(tries), 32'd3);
    check("t2_seed_used", 32'(seed_used), 32'hA);
    tick();

    // Zero base seed becomes 1; grid always fails -> give up after 8.
    accept(4'h0);
    check("t3_seed_zero_sub", 32'(grid_seed), 32'h1);
    for (int i = 0; i < 8; i++) begin
      wait_launch();
      check("t3_seed_nonzero", 32'(grid_seed != 4'h0), 32'd1);
      finish_attempt(1'b0);
    end
    check("t3_done", 32'(done), 32'd1);
    check("t3_success", 32'(success), 32'd0);
    check("t3_tries", 32'(tries), 32'd8);
    check("t3_seed_used", 32'(seed_used), 32'h9);
    tick();

    // Abort beats same-cycle grid success on try 2.
    accept(4'h2);
    wait_launch();
    finish_attempt(1'b0);
    wait_launch();
    rq_abort = 1'b1;
    finish_attempt(1'b1);
    rq_abort = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_success", 32'(success), 32'd0);
    check("t4_tries", 32'(tries), 32'd2);
    check("t4_seed_used", 32'(seed_used), 32'h7);
    tick();

    // Abort during CLEAR.
    accept(4'h6);
    rq_abort = 1'b1;
    tick();
    rq_abort = 1'b0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_success", 32'(success), 32'd0);
    check("t5_tries", 32'(tries), 32'd1);
    check("t5_gr_off", 32'(grid_reset), 32'd0);
    tick();

    // Asynchronous reset between clock edges mid-LAUNCH.
    accept(4'h5);
    wait_launch();
    #2;
    reset = 1'b1;
    #1;
    check("t6_gr", 32'(grid_reset), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_start", 32'(grid_rq_start), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    tick();
    check("t6_done_hold", 32'(done), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    check("t6_gr_release", 32'(grid_reset), 32'd0);
    accept(4'h4);
    wait_launch();
    finish_attempt(1'b1);
    check("t6_after_done", 32'(done), 32'd1);
    check("t6_after_success", 32'(success), 32'd1);
    check("t6_after_tries", 32'(tries), 32'd1);
    check("t6_after_seed", 32'(seed_used), 32'h4);

    // rq_gen held through REPORT starts the next job one cycle after done.
    rq_gen = 1'b1;
    base_seed = 4'h8;
    tick();
    check("t7_idle_gap", 32'(busy), 32'd0);
    tick();
    rq_gen = 1'b0;
    check("t7_busy", 32'(busy), 32'd1);
    check("t7_gr", 32'(grid_reset), 32'd1);
    check("t7_seed", 32'(grid_seed), 32'h8);
    wait_launch();
    finish_attempt(1'b1);
    check("t7_done", 32'(done), 32'd1);
    tick();

`ifdef GRID_GEN_TIMEOUT_EN
    // Grid never finishes: each attempt is 17 LAUNCH cycles, then retry/fail.
    accept(4'h1);
    for (int i = 0; i < 8; i++) begin
      int hi = 0;
      wait_launch();
      while (grid_rq_start && hi < 100) begin
        tick();
        hi++;
      end
      check("t8_launch_len", 32'(hi), 32'd17);
    end
    check("t8_done", 32'(done), 32'd1);
    check("t8_success", 32'(success), 32'd0);
    check("t8_tries", 32'(tries), 32'd8);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_gen_sequencer.md
# grid_gen_sequencer

Controller that sits above `grid` and runs complete puzzle-generation jobs for a host. It pulses the grid's reset, supplies a seed, and launches the grid. If an attempt fails, it retries with a new nonzero seed, up to a fixed number of attempts. It then reports the outcome, attempt count and final seed to the host with a one-cycle completion pulse.

## Interface
Parameters:
- `LFSR_WIDTH`, 4: seed width; must match the grid instance.
- `MAX_TRIES`, 8: attempts per job, ≥1. `TRY_W = $clog2(MAX_TRIES+1)`.
- `SEED_STRIDE`, 5: odd value added to the seed between attempts.
- `CLEAR_CYCLES`, 2: cycles `grid_reset` is held per attempt, ≥1.
- `TIMEOUT_CYCLES`, 4096: per-attempt watchdog limit. Used only with `GRID_GEN_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock. Everything is rising-edge.
- `reset` in 1: reset is asynchronous and active-high.
- `rq_gen` in 1: job request. Sampled only in IDLE.
- `rq_abort` in 1: abort the current job. Ignored in IDLE.
- `base_seed` in LFSR_WIDTH: first seed. Captured on accept. Zero is replaced by 1.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `success` out 1: job result. Valid from the `done` cycle until the next accept.
- `tries` out TRY_W: attempts used. Valid with `success`.
- `seed_used` out LFSR_WIDTH: seed of the last attempt.
- `grid_reset` out 1: drives `grid.reset`.
- `grid_rq_start` out 1: drives `grid.rq_start`.
- `grid_seed` out LFSR_WIDTH: drives `grid.seed`.
- `grid_done`, `grid_success` in 1: from `grid`.

## Operation
- States: IDLE, CLEAR, LAUNCH, REPORT. All outputs are registered.
- IDLE:
  - `rq_gen=1` → CLEAR.
  - On accept: seed ← `base_seed` (or 1 if zero), try count ← 1, `success` ← 0.
- CLEAR:
  - `grid_reset=1` for exactly CLEAR_CYCLES cycles, then → LAUNCH.
  - `grid_seed` is stable from CLEAR entry through the end of LAUNCH.
- LAUNCH:
  - `grid_rq_start=1` is held until `grid_done` is seen. The grid waits internally for its `ready`.
  - On `grid_done=1` with `grid_success=1` → REPORT with success.
  - On `grid_done=1` with `grid_success=0`, and tries = MAX_TRIES → REPORT with failure.
  - On `grid_done=1` with `grid_success=0` otherwise → step the seed, try count +1, → CLEAR.
- Seed step: s' = (s + SEED_STRIDE) mod 2^LFSR_WIDTH. If s' = 0, s' = SEED_STRIDE mod 2^LFSR_WIDTH; if that is also 0, s' = 1. `grid_seed` is never 0.
- REPORT:
  - `done=1` for one cycle, then → IDLE.
  - `success`, `tries` and `seed_used` are latched and held until the next accept.
- Abort:
  - `rq_abort=1` in CLEAR or LAUNCH → REPORT with `success=0`; `tries` keeps the current count.
  - Abort beats a same-cycle `grid_done`.
- IDLE outputs: `grid_reset=0`, `grid_rq_start=0`. The grid keeps its finished result readable.

## Timing
- Reset values:
  - `busy`, `done`, `success`, `grid_rq_start` = 0.
  - `tries` = 0, `seed_used` = 0.
  - `grid_seed` = 1.
  - `grid_reset` = 1, so the grid is held in reset while the sequencer is in reset.
  - State = IDLE. `grid_reset` falls on the first clock after `reset` deasserts.
- Accept at edge t:
  - `busy` = 1 and `grid_reset` = 1 at cycles t+1 … t+CLEAR_CYCLES.
  - `grid_rq_start` = 1 from t+CLEAR_CYCLES+1.
- `grid_done` sampled at edge u → `done` pulse at u+1, or CLEAR re-entry at u+1.
- A retry costs CLEAR_CYCLES + 1 cycles of overhead.
- `rq_gen` held high through REPORT starts a new job on the cycle after `done`. There is no back-to-back accept in REPORT.
- Asynchronous `reset` mid-job forces the reset values immediately. No `done` pulse is issued.

## Configuration
- `GRID_GEN_TIMEOUT_EN` defined:
  - A counter runs in LAUNCH and clears on CLEAR entry.
  - Reaching TIMEOUT_CYCLES with no `grid_done` is treated exactly as `grid_done=1` with `grid_success=0`, i.e. retry or fail.
- `GRID_GEN_TIMEOUT_EN` undefined:
  - No counter and no `TIMEOUT_CYCLES` logic.
  - LAUNCH waits indefinitely for `grid_done` or `rq_abort`.

## Structure
- Package `grid_gen_pkg`:
  - state enum `gen_state_t`.
  - function `f_seed_step(seed, stride, width)`.
  - default constants for the parameters above.
- Sub-module `grid_gen_watchdog`: counter plus expiry flag, with `clear` and `run` inputs. It is instantiated only under `GRID_GEN_TIMEOUT_EN`.
- The FSM, seed register and try counter stay in `grid_gen_sequencer`.

## Test plan
- Model grid succeeds on its first `grid_done`. `base_seed=4'h3`, `rq_gen` pulse → `grid_reset` high for 2 cycles, `grid_seed=3`, `done` one cycle later with `success=1`, `tries=1`, `seed_used=3`.
- Grid fails twice, then succeeds. `base_seed=4'hB`, stride 5 → seeds 0xB, 0x0→0x5, 0xA; `tries=3`, `success=1`. `grid_seed` is never 0.
- Grid always fails, MAX_TRIES=8 → 8 CLEAR/LAUNCH rounds, then `done` with `success=0` and `tries=8`.
- `rq_abort` in the same cycle as `grid_done`/`grid_success=1` on try 2 → `done` next cycle with `success=0` and `tries=2`.
- Async `reset` asserted mid-LAUNCH, between clock edges → `grid_reset=1`, `busy=0` and `grid_rq_start=0` immediately; no `done`. A new request afterwards completes normally.
- With `GRID_GEN_TIMEOUT_EN` and TIMEOUT_CYCLES=16, grid never finishes → a retry every 16 + 3 cycles, final `done` with `success=0` and `tries=MAX_TRIES`.
